// File: rtl/motor_pkg.sv
// Shared types and helpers for the multi-channel signed motor PWM controller.
// Slew limiting is enabled by defining MOTOR_CNTRL_SLEW_EN.
package motor_pkg;

  localparam int MAXW = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BRAKE = 3'd1,
    ST_FWD   = 3'd2,
    ST_REV   = 3'd3,
    ST_DEAD  = 3'd4
  } mstate_e;

  function automatic logic [MAXW-1:0] cnt_max(
    input int unsigned w
  );
    return (MAXW'(1) << w) - MAXW'(1);
  endfunction

  // Most-negative command saturates to full scale instead of wrapping to 0.
  function automatic logic [MAXW-1:0] cmd_mag(
    input logic [MAXW:0] c,
    input int unsigned   w
  );
    logic [MAXW:0] n;
    n = c[MAXW] ? -c : c;
    if (n > {1'b0, cnt_max(w)})
      n = {1'b0, cnt_max(w)};
    return n[MAXW-1:0];
  endfunction

endpackage

// File: rtl/motor_chan.sv
// One motor channel: period-boundary sampling, direction FSM, dead time, PWM compare.
// Defining MOTOR_CNTRL_SLEW_EN limits magnitude change to SLEW_STEP per period.
module motor_chan
  import motor_pkg::*;
#(
  parameter int PWM_W     = 10,
  parameter int DEAD_PER  = 1,
  parameter int SLEW_STEP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic             i_strb,
  input  logic [PWM_W:0]   i_cmd,
  output logic             o_fwd,
  output logic             o_rev,
  output logic             o_dead
);

  localparam int DW = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
  localparam logic [DW-1:0] DINIT =
    DW'((DEAD_PER > 0) ? DEAD_PER - 1 : 0);

`ifdef MOTOR_CNTRL_SLEW_EN
  localparam logic [PWM_W:0] STEP = (PWM_W+1)'(SLEW_STEP);
`else
  // A step wider than full scale makes every move instantaneous.
  localparam logic [PWM_W:0] STEP =
    (PWM_W+1)'(SLEW_STEP) | {1'b1, PWM_W'(0)};
`endif

  function automatic logic [PWM_W-1:0] slew(
    input logic [PWM_W-1:0] a,
    input logic [PWM_W-1:0] b
  );
    logic [PWM_W:0] d;
    if (b > a) begin
      d = {1'b0, b - a};
      return (d > STEP) ? a + STEP[PWM_W-1:0] : b;
    end
    d = {1'b0, a - b};
    return (d > STEP) ? a - STEP[PWM_W-1:0] : b;
  endfunction

  mstate_e          r_state;
  logic [PWM_W-1:0] r_mag;
  logic [DW-1:0]    r_dcnt;
  logic             r_fwd;
  logic             r_rev;
  logic             r_dead;

  logic [MAXW:0]    w_cmd_x;
  logic [PWM_W-1:0] w_mag;
  mstate_e          w_tgt;
  logic [PWM_W-1:0] w_up;
  logic [PWM_W-1:0] w_dn;
  logic [PWM_W-1:0] w_st;

  assign w_cmd_x = {{(MAXW-PWM_W){i_cmd[PWM_W]}}, i_cmd};
  assign w_mag   = PWM_W'(cmd_mag(w_cmd_x, PWM_W));
  assign w_tgt   = (i_cmd == '0) ? ST_BRAKE :
                   i_cmd[PWM_W]  ? ST_REV : ST_FWD;
  assign w_up    = slew(r_mag, w_mag);
  assign w_dn    = slew(r_mag, '0);
  assign w_st    = slew('0, w_mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mag   <= '0;
      r_dcnt  <= '0;
      r_fwd   <= 1'b0;
      r_rev   <= 1'b0;
      r_dead  <= 1'b0;
    end else begin
      r_fwd  <= (r_state == ST_BRAKE) ||
                (r_state == ST_FWD && i_cnt < r_mag);
      r_rev  <= (r_state == ST_BRAKE) ||
                (r_state == ST_REV && i_cnt < r_mag);
      r_dead <= (r_state == ST_DEAD);
      if (i_strb) begin
        unique case (r_state)
          ST_IDLE, ST_BRAKE: begin
            r_state <= w_tgt;
            r_mag   <= w_st;
          end
          ST_FWD, ST_REV: begin
            if (w_tgt == r_state) begin
              r_mag <= w_up;
            end else if (w_dn != '0) begin
              r_mag <= w_dn;
            end else if (w_tgt == ST_BRAKE) begin
              r_state <= ST_BRAKE;
              r_mag   <= '0;
            end else if (DEAD_PER == 0) begin
              r_state <= w_tgt;
              r_mag   <= w_st;
            end else begin
              r_state <= ST_DEAD;
              r_dcnt  <= DINIT;
              r_mag   <= '0;
            end
          end
          ST_DEAD: begin
            if (r_dcnt == '0) begin
              r_state <= w_tgt;
              r_mag   <= w_st;
            end else begin
              r_dcnt <= r_dcnt - DW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_fwd  = r_fwd;
  assign o_rev  = r_rev;
  assign o_dead = r_dead;

endmodule

// File: rtl/motor_cntrl_mc.sv
// Multi-channel signed motor controller: shared PWM period counter and strobe.
// Optional slew limiting per channel via MOTOR_CNTRL_SLEW_EN.
module motor_cntrl_mc
  import motor_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int PWM_W     = 10,
  parameter int DEAD_PER  = 1,
  parameter int SLEW_STEP = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH*(PWM_W+1)-1:0] cmd,
  output logic [NCH-1:0]           fwd,
  output logic [NCH-1:0]           rev,
  output logic [NCH-1:0]           dead,
  output logic                     prd_strb
);

  localparam logic [PWM_W-1:0] CNT_MAX = PWM_W'(cnt_max(PWM_W));

  logic [PWM_W-1:0] r_cnt;
  logic             r_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_strb <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + PWM_W'(1);
      r_strb <= (r_cnt == CNT_MAX - PWM_W'(1));
    end
  end

  assign prd_strb = r_strb;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    motor_chan #(
      .PWM_W    (PWM_W),
      .DEAD_PER (DEAD_PER),
      .SLEW_STEP(SLEW_STEP)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .i_cnt (r_cnt),
      .i_strb(r_strb),
      .i_cmd (cmd[g*(PWM_W+1) +: PWM_W+1]),
      .o_fwd (fwd[g]),
      .o_rev (rev[g]),
      .o_dead(dead[g])
    );
  end

endmodule

// File: tb/tb_motor_cntrl_mc.sv
// Directed bench for motor_cntrl_mc: NCH=2, PWM_W=10, DEAD_PER=2.
// Per-period output counts are compared against hand-computed duties.
module tb_motor_cntrl_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [21:0] cmd = '0;
  logic [1:0]  fwd, rev, dead;
  logic        prd_strb;

  int ntests = 0;
  int nfail  = 0;
  int nf[2], nr[2], nd[2], nb[2];
  int nstrb, strb_pos, waited, nz;

  motor_cntrl_mc #(
    .NCH(2), .PWM_W(10), .DEAD_PER(2), .SLEW_STEP(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd),
    .fwd(fwd), .rev(rev), .dead(dead), .prd_strb(prd_strb)
  );

  always #5 clk = ~clk;

  // Wait for the period strobe, counting non-idle outputs, then step to cnt=1.
  task automatic wait_boundary();
    waited = 0;
    nz = 0;
    do begin
      @(negedge clk);
      waited++;
      if ((fwd | rev | dead) != 2'b00) nz++;
    end while (!prd_strb && waited < 2048);
    if (!prd_strb) begin
      ntests++; nfail++;
      $display("FAIL boundary_timeout waited %0d cycles", waited);
    end
    @(posedge clk);
    @(posedge clk);
  endtask

  // Count outputs over one full output window (cnt=1..1023, then 0).
  task automatic measure(input int chg_idx, input logic [10:0] chg_val);
    for (int c = 0; c < 2; c++) begin
      nf[c] = 0; nr[c] = 0; nd[c] = 0; nb[c] = 0;
    end
    nstrb = 0;
    strb_pos = -1;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (k == chg_idx) cmd[10:0] = chg_val;
      for (int c = 0; c < 2; c++) begin
        nf[c] += int'(fwd[c]);
        nr[c] += int'(rev[c]);
        nd[c] += int'(dead[c]);
        nb[c] += int'(fwd[c] & rev[c]);
      end
      if (prd_strb) begin
        nstrb++;
        strb_pos = k;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ntests++;
    if ({fwd, rev, dead} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_outs got %b exp 000000", {fwd, rev, dead});
    end
    ntests++;
    if (prd_strb !== 1'b0) begin
      nfail++;
      $display("FAIL reset_strb got %b exp 0", prd_strb);
    end
    rst_n = 1'b1;
    wait_boundary();
    ntests++;
    if (waited !== 1023) begin
      nfail++;
      $display("FAIL first_strb got %0d exp 1023", waited);
    end
    ntests++;
    if (nz !== 0) begin
      nfail++;
      $display("FAIL idle_outs got %0d exp 0", nz);
    end
  endtask

  task automatic test_fwd_brake();
    measure(-1, 11'd0);
    ntests++;
    if (nf[0] !== 256 || nr[0] !== 0) begin
      nfail++;
      $display("FAIL fwd256 got f=%0d r=%0d exp f=256 r=0", nf[0], nr[0]);
    end
    ntests++;
    if (nb[1] !== 1024) begin
      nfail++;
      $display("FAIL brake got %0d exp 1024", nb[1]);
    end
    ntests++;
    if (nstrb !== 1 || strb_pos !== 1022) begin
      nfail++;
      $display("FAIL strb got n=%0d pos=%0d exp n=1 pos=1022", nstrb, strb_pos);
    end
  endtask

  task automatic test_saturation();
    cmd[10:0]  = 11'd512;
    cmd[21:11] = 11'b100_0000_0000;
    measure(-1, 11'd0);
    ntests++;
    if (nf[0] !== 256 || nb[1] !== 1024) begin
      nfail++;
      $display("FAIL no_early_update got f0=%0d b1=%0d exp 256 1024", nf[0], nb[1]);
    end
    measure(-1, 11'd0);
    ntests++;
    if (nr[1] !== 1023 || nf[1] !== 0) begin
      nfail++;
      $display("FAIL saturate got r=%0d f=%0d exp r=1023 f=0", nr[1], nf[1]);
    end
    ntests++;
    if (nf[0] !== 512) begin
      nfail++;
      $display("FAIL fwd512 got %0d exp 512", nf[0]);
    end
  endtask

  task automatic test_reversal();
    logic [10:0] v;
    v = 11'(-300);
    measure(500, v);
    ntests++;
    if (nf[0] !== 512 || nb[0] !== 0) begin
      nfail++;
      $display("FAIL rev_finish got f=%0d b=%0d exp 512 0", nf[0], nb[0]);
    end
    for (int p = 0; p < 2; p++) begin
      measure(-1, v);
      ntests++;
      if (nd[0] !== 1024 || nf[0] !== 0 || nr[0] !== 0) begin
        nfail++;
        $display("FAIL dead_%0d got d=%0d f=%0d r=%0d exp 1024 0 0", p, nd[0], nf[0], nr[0]);
      end
    end
    measure(-1, v);
    ntests++;
    if (nr[0] !== 300 || nf[0] !== 0 || nd[0] !== 0) begin
      nfail++;
      $display("FAIL rev300 got r=%0d f=%0d d=%0d exp 300 0 0", nr[0], nf[0], nd[0]);
    end
    ntests++;
    if (nr[1] !== 1023) begin
      nfail++;
      $display("FAIL ch1_hold got %0d exp 1023", nr[1]);
    end
  endtask

  task automatic test_mid_update();
    int exp_f[4];
    int idx[4];
    logic [10:0] val[4];
    cmd[10:0] = 11'd100;
    measure(-1, 11'd100);
    ntests++;
    if (nr[0] !== 300) begin
      nfail++;
      $display("FAIL rev_hold got %0d exp 300", nr[0]);
    end
    for (int p = 0; p < 2; p++) begin
      measure(-1, 11'd100);
      ntests++;
      if (nd[0] !== 1024) begin
        nfail++;
        $display("FAIL dead2_%0d got %0d exp 1024", p, nd[0]);
      end
    end
    exp_f = '{100, 100, 900, 100};
    idx   = '{-1, 300, 300, -1};
    val   = '{11'd100, 11'd900, 11'd100, 11'd100};
    for (int p = 0; p < 4; p++) begin
      measure(idx[p], val[p]);
      ntests++;
      if (nf[0] !== exp_f[p] || nr[0] !== 0 || nb[0] !== 0) begin
        nfail++;
        $display("FAIL duty_%0d got f=%0d r=%0d exp f=%0d r=0", p, nf[0], nr[0], exp_f[p]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    @(negedge clk);
    ntests++;
    if (fwd[0] !== 1'b1) begin
      nfail++;
      $display("FAIL pre_rst_fwd got %b exp 1", fwd[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    ntests++;
    if ({fwd, rev, dead, prd_strb} !== 7'b0) begin
      nfail++;
      $display("FAIL async_rst got %b exp 0000000", {fwd, rev, dead, prd_strb});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_boundary();
    ntests++;
    if (waited !== 1023 || nz !== 0) begin
      nfail++;
      $display("FAIL restart got wait=%0d nz=%0d exp 1023 0", waited, nz);
    end
    measure(-1, 11'd100);
    ntests++;
    if (nf[0] !== 100 || nr[1] !== 1023) begin
      nfail++;
      $display("FAIL post_rst got f0=%0d r1=%0d exp 100 1023", nf[0], nr[1]);
    end
  endtask

  task automatic test_slew();
    int exp_f[5];
    cmd[10:0] = 11'd64;
    measure(-1, 11'd64);
    ntests++;
    if (nb[0] !== 1024) begin
      nfail++;
      $display("FAIL slew_brake got %0d exp 1024", nb[0]);
    end
    exp_f = '{16, 32, 48, 64, 64};
    for (int p = 0; p < 5; p++) begin
      measure(-1, 11'd64);
      ntests++;
      if (nf[0] !== exp_f[p] || nr[0] !== 0) begin
        nfail++;
        $display("FAIL slew_%0d got f=%0d r=%0d exp f=%0d r=0", p, nf[0], nr[0], exp_f[p]);
      end
    end
  endtask

  initial begin
`ifdef MOTOR_CNTRL_SLEW_EN
    cmd = '0;
    test_reset();
    test_slew();
`else
    cmd[10:0]  = 11'd256;
    cmd[21:11] = 11'd0;
    test_reset();
    test_fwd_brake();
    test_saturation();
    test_reversal();
    test_mid_update();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/motor_cntrl_mc.md
Name: motor_cntrl_mc

Overview:
Parametrised multi-channel successor to the two-channel signed motor controller. Converts NCH signed drive commands into per-channel fwd/rev PWM pairs from one shared period counter. Adds:
- glitch-free command update at period boundaries
- a per-channel direction state machine with programmable dead time on reversal
- saturation of the most-negative command

Sits between the drive-command logic and the H-bridge pins.

Parameters:
NCH, 2, number of motor channels
PWM_W, 10, PWM resolution in bits; period = 2^PWM_W clk cycles
DEAD_PER, 1, dead time in whole PWM periods on a direction reversal; 0 = reverse immediately
SLEW_STEP, 16, maximum magnitude change per period (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd  in  NCH*(PWM_W+1)  packed signed two's-complement commands; channel i occupies bits [i*(PWM_W+1) +: PWM_W+1]
fwd  out  NCH  forward drive per channel
rev  out  NCH  reverse drive per channel
dead  out  NCH  high while the channel is in DEAD state
prd_strb  out  1  one-cycle pulse on the last cycle of each PWM period

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting rst_n=0 forces:
  - counter = 0
  - every channel to IDLE
  - fwd = 0, rev = 0, dead = 0, prd_strb = 0
  - latched magnitude = 0
- Reset mid-period: outputs drop to 0 asynchronously. Operation restarts at counter 0 after release.
- Counter: free-running PWM_W-bit count 0 to 2^PWM_W-1, wrapping to 0. prd_strb is registered and high in the cycle the counter equals 2^PWM_W-1.
- Magnitude: mag = cmd when sign = 0. mag = -cmd when sign = 1. Special case: cmd = 100…0 gives mag = 2^PWM_W-1 (saturated, never zero).
- Sampling: each channel samples cmd only in the cycle prd_strb is high. The new duty, direction and state take effect from counter = 0 of the next period. cmd changes mid-period have no effect.
- Target direction from the sampled cmd: ZERO when cmd = 0, FWD when sign = 0, REV when sign = 1.
- Per-channel FSM; transitions only at a sample point:
  - IDLE → BRAKE, FWD or REV per target.
  - BRAKE → FWD or REV per target.
  - FWD ↔ BRAKE, and REV ↔ BRAKE, immediately.
  - FWD → REV or REV → FWD: enter DEAD with dcnt = DEAD_PER-1. If DEAD_PER = 0, switch direction directly.
  - DEAD: target is re-latched at every sample point. At a sample point with dcnt = 0, exit to the latest target (BRAKE/FWD/REV). Otherwise decrement dcnt.
  - A same-direction target while in DEAD does not abort the dead time.
- Outputs, registered, one cycle after the counter value they reflect:
  - IDLE: fwd = 0, rev = 0.
  - BRAKE: fwd = 1, rev = 1.
  - FWD: fwd = (cnt < mag), rev = 0.
  - REV: rev = (cnt < mag), fwd = 0.
  - DEAD: fwd = 0, rev = 0, dead = 1.
- Duty boundaries: mag = 2^PWM_W-1 gives high for all but one cycle per period. mag = 1 gives high for exactly one cycle.
- Invariant: fwd and rev are never both 1 except in BRAKE. Neither is ever 1 in the cycle a reversal occurs.

Optional Feature:
Macro MOTOR_CNTRL_SLEW_EN.
- Defined: at each sample point the applied magnitude moves toward the target magnitude by at most SLEW_STEP.
  - A reversal first ramps down to 0 in the current direction, then enters DEAD.
  - Ramp-up after DEAD starts from 0.
  - BRAKE is entered only once the applied magnitude reaches 0.
- Not defined: the applied magnitude equals the sampled mag immediately. SLEW_STEP is ignored.

Decomposition:
- Package motor_pkg holds:
  - the state encoding (IDLE, BRAKE, FWD, REV, DEAD; 3 bits)
  - the magnitude/saturation function
  - the localparam for counter maximum
- One sub-module, motor_chan: per-channel sampling, FSM, dead counter, slew logic and comparator.
- The top level holds the shared counter and prd_strb, and generates NCH instances of motor_chan.

Test Plan:
1. Reset released with cmd = +256 on ch0, PWM_W = 10 → fwd = rev = 0 until the first period boundary; then fwd high 256 of 1024 cycles, rev = 0.
2. cmd = 0 on ch1 → after the next boundary, fwd = rev = 1 continuously (BRAKE).
3. cmd = 11'b100_0000_0000 → rev high 1023 of 1024 cycles, fwd = 0 (saturation).
4. ch0 running at +512, then cmd set to -300 mid-period with DEAD_PER = 2 → current period finishes at 512; then 2 full periods with fwd = rev = 0 and dead = 1; then rev high 300 cycles per period.
5. cmd toggled between +100 and +900 mid-period → the duty changes only at the period boundary; no pulse width other than 100 or 900 appears.
6. rst_n pulsed low mid-period while in FWD → fwd drops within the same cycle; after release the channel restarts from IDLE. With MOTOR_CNTRL_SLEW_EN and SLEW_STEP = 16, a step from 0 to +64 yields duties of 16, 32, 48 and 64 over successive periods.
